// File: rtl/memory_latency_if.sv
// memory_latency_if: request/response bundle between a CPU memory port and memory_latency
interface memory_latency_if #(parameter int DW = 16, parameter int AW = 16);
  logic          req_en;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready;
  logic          rsp_valid;
  logic          rsp_wr;
  logic [DW-1:0] rsp_data;
  logic          busy;
  modport master (output req_en, req_wr, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_wr, rsp_data, busy);
  modport slave  (input  req_en, req_wr, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_wr, rsp_data, busy);
endinterface

// File: rtl/memory_latency.sv
// memory_latency: word memory with configurable latency, blocking or in-order pipelined
module memory_latency #(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int DEPTH_LOG2 = 15,
  parameter int LATENCY = 4,
  parameter int PIPELINED = 0
) (
  input logic              clk,
  input logic              rst_n,
  memory_latency_if.slave  io_bus
);
  logic [DW-1:0]         r_mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [DW-1:0]         w_din;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_unused;
  assign w_idx = io_bus.req_addr[DEPTH_LOG2:1];
  assign w_unused = ^io_bus.req_addr;
  assign w_accept = io_bus.req_en & w_ready & rst_n;
  // reads capture the array at acceptance, so later writes never disturb in-flight data
  assign w_din = io_bus.req_wr ? io_bus.req_wdata : r_mem[w_idx];
  assign io_bus.req_ready = w_ready;
  always_ff @(posedge clk)
    if (w_accept && io_bus.req_wr) r_mem[w_idx] <= io_bus.req_wdata;
  if (PIPELINED != 0) begin : g_pipe
    logic [LATENCY-1:0] r_v;
    logic [LATENCY-1:0] r_w;
    logic [DW-1:0]      r_d [LATENCY];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_v <= '0;
        r_w <= '0;
        for (int k = 0; k < LATENCY; k++) r_d[k] <= '0;
      end else begin
        r_v[0] <= w_accept;
        if (w_accept) begin
          r_w[0] <= io_bus.req_wr;
          r_d[0] <= w_din;
        end
        for (int k = 1; k < LATENCY; k++) begin
          r_v[k] <= r_v[k-1];
          if (r_v[k-1]) begin
            r_w[k] <= r_w[k-1];
            r_d[k] <= r_d[k-1];
          end
        end
      end
    assign w_ready = 1'b1;
    assign io_bus.rsp_valid = r_v[LATENCY-1];
    assign io_bus.rsp_wr = r_w[LATENCY-1];
    assign io_bus.rsp_data = r_d[LATENCY-1];
    assign io_bus.busy = |r_v;
  end else begin : g_blk
    typedef enum logic {IDLE, WAIT} state_t;
    localparam int CW = $clog2(LATENCY + 1);
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_sw, r_rv, r_rw;
    logic [DW-1:0] r_sd, r_rd;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_state <= IDLE;
        r_cnt <= '0;
        r_sw <= 1'b0;
        r_sd <= '0;
        r_rv <= 1'b0;
        r_rw <= 1'b0;
        r_rd <= '0;
      end else begin
        r_rv <= 1'b0;
        if (r_state == WAIT && r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        if (r_state == WAIT && r_cnt == CW'(1)) begin
          r_rv <= 1'b1;
          r_rw <= r_sw;
          r_rd <= r_sd;
        end
        if (r_state == WAIT && r_cnt == '0) r_state <= IDLE;
        // a single-cycle memory answers straight from the acceptance edge
        if (w_accept && LATENCY == 1) begin
          r_rv <= 1'b1;
          r_rw <= io_bus.req_wr;
          r_rd <= w_din;
        end else if (w_accept) begin
          r_state <= WAIT;
          r_cnt <= CW'(LATENCY - 1);
          r_sw <= io_bus.req_wr;
          r_sd <= w_din;
        end
      end
    assign w_ready = (r_state == IDLE) || (r_cnt == '0);
    assign io_bus.rsp_valid = r_rv;
    assign io_bus.rsp_wr = r_rw;
    assign io_bus.rsp_data = r_rd;
    assign io_bus.busy = (r_state == WAIT) | r_rv;
  end
endmodule
